// File: rtl/regfile_access_ctrl.sv
// Single-port scheduler in front of a 32x32 register file: clears the file after reset,
// arbitrates writeback writes against decode reads, and holds read responses under backpressure.
//   state   | meaning
//   ST_INIT | register file being cleared, no grants
//   ST_RUN  | normal arbitration, left only by reset
module regfile_access_ctrl #(
    parameter int MAX_WR_STREAK = 4,
    parameter int INIT_CYCLES   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [4:0]  i_wr_rd,
    input  logic [31:0] i_wr_data,
    input  logic        i_rd_valid,
    output logic        o_rd_ready,
    input  logic [4:0]  i_rd_rs1,
    input  logic [4:0]  i_rd_rs2,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rs1,
    output logic [31:0] o_resp_rs2,
    output logic        o_init_done,
    output logic        o_rf_rst,
    output logic        o_rf_read,
    output logic [4:0]  o_rf_rd,
    output logic [4:0]  o_rf_rs1,
    output logic [4:0]  o_rf_rs2,
    output logic [31:0] o_rf_data_in,
    input  logic [31:0] i_rf_rs1_out,
    input  logic [31:0] i_rf_rs2_out
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_init_cnt;
    logic [3:0]  r_streak;
    logic        r_resp_valid;
    logic        r_resp_first;
    logic        r_rs1_zero;
    logic        r_rs2_zero;
    logic [31:0] r_hold_rs1;
    logic [31:0] r_hold_rs2;

    logic        w_run;
    logic        w_init_last;
    logic        w_rd_elig;
    logic        w_wr_x0;
    logic        w_wr_nz;
    logic        w_wr_grant;
    logic        w_rd_grant;
    logic [31:0] w_first_rs1;
    logic [31:0] w_first_rs2;

    assign w_init_last = (r_init_cnt == 4'(INIT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_run       = (r_state == ST_RUN);
        o_init_done = w_run;
        o_rf_rst    = !w_run;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_cnt <= 4'd0;
        end else if (r_state == ST_INIT && !w_init_last) begin
            r_init_cnt <= r_init_cnt + 4'd1;
        end
    end

    // A stalled response blocks new reads; a read may still issue in the cycle the old one is taken.
    assign w_rd_elig  = w_run && i_rd_valid && !(r_resp_valid && !i_resp_ready);
    assign w_wr_x0    = w_run && i_wr_valid && (i_wr_rd == 5'd0);
    assign w_wr_nz    = w_run && i_wr_valid && (i_wr_rd != 5'd0);
    assign w_wr_grant = w_wr_nz && !(w_rd_elig && (r_streak == 4'(MAX_WR_STREAK)));
    assign w_rd_grant = w_rd_elig && !w_wr_grant;

    assign o_wr_ready   = w_wr_grant || w_wr_x0;
    assign o_rd_ready   = w_rd_grant;
    assign o_rf_read    = !w_wr_grant;
    assign o_rf_rd      = w_wr_grant ? i_wr_rd   : 5'd0;
    assign o_rf_data_in = w_wr_grant ? i_wr_data : 32'd0;
    assign o_rf_rs1     = w_rd_grant ? i_rd_rs1  : 5'd0;
    assign o_rf_rs2     = w_rd_grant ? i_rd_rs2  : 5'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_streak <= 4'd0;
        end else if (w_rd_elig && w_wr_grant) begin
            r_streak <= r_streak + 4'd1;
        end else begin
            r_streak <= 4'd0;
        end
    end

    assign w_first_rs1 = r_rs1_zero ? 32'd0 : i_rf_rs1_out;
    assign w_first_rs2 = r_rs2_zero ? 32'd0 : i_rf_rs2_out;

    // Register-file outputs are only valid in the first response cycle; afterwards use the hold copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_first <= 1'b0;
            r_rs1_zero   <= 1'b0;
            r_rs2_zero   <= 1'b0;
            r_hold_rs1   <= 32'd0;
            r_hold_rs2   <= 32'd0;
        end else begin
            r_resp_valid <= w_rd_grant || (r_resp_valid && !i_resp_ready);
            r_resp_first <= w_rd_grant;
            if (w_rd_grant) begin
                r_rs1_zero <= (i_rd_rs1 == 5'd0);
                r_rs2_zero <= (i_rd_rs2 == 5'd0);
            end
            if (r_resp_first && !i_resp_ready) begin
                r_hold_rs1 <= w_first_rs1;
                r_hold_rs2 <= w_first_rs2;
            end
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rs1   = r_resp_first ? w_first_rs1 : r_hold_rs1;
    assign o_resp_rs2   = r_resp_first ? w_first_rs2 : r_hold_rs2;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized bench for regfile_access_ctrl with a behavioural register-file model
// and a reference model of arbitration, register contents and responses.
module tb_regfile_access_ctrl;

    localparam int MAX_WR_STREAK = 2;
    localparam int INIT_CYCLES   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0, rd_valid = 1'b0, resp_ready = 1'b0;
    logic [4:0]  wr_rd = '0, rd_rs1 = '0, rd_rs2 = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, rd_ready, resp_valid, init_done, rf_rst, rf_read;
    logic [31:0] resp_rs1, resp_rs2, rf_data_in;
    logic [4:0]  rf_rd, rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_out, rf_rs2_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.MAX_WR_STREAK(MAX_WR_STREAK), .INIT_CYCLES(INIT_CYCLES)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_rd(wr_rd), .i_wr_data(wr_data),
        .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_rs1(rd_rs1), .i_rd_rs2(rd_rs2),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rs1(resp_rs1), .o_resp_rs2(resp_rs2),
        .o_init_done(init_done), .o_rf_rst(rf_rst), .o_rf_read(rf_read),
        .o_rf_rd(rf_rd), .o_rf_rs1(rf_rs1), .o_rf_rs2(rf_rs2), .o_rf_data_in(rf_data_in),
        .i_rf_rs1_out(rf_rs1_out), .i_rf_rs2_out(rf_rs2_out)
    );

    // Register file: synchronous clear, registered read data, write op zeroes the outputs.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_rs1_out <= '0;
            rf_rs2_out <= '0;
        end else if (rf_read) begin
            rf_rs1_out <= rf_mem[rf_rs1];
            rf_rs2_out <= rf_mem[rf_rs2];
        end else begin
            rf_mem[rf_rd] <= rf_data_in;
            rf_rs1_out <= '0;
            rf_rs2_out <= '0;
        end
    end

    // Reference model state
    int          m_init_left;
    int          m_streak;
    logic [31:0] m_regs [32];
    logic        m_resp_valid;
    logic [31:0] m_resp1, m_resp2;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init_left  = INIT_CYCLES;
        m_streak     = 0;
        m_resp_valid = 1'b0;
        m_resp1      = '0;
        m_resp2      = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic step(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic rv, input logic [4:0] s1, input logic [4:0] s2, input logic rr);
        bit run, elig, wnz, wx0, rg, wg;
        @(negedge clk);
        wr_valid = wv; wr_rd = wrd; wr_data = wd;
        rd_valid = rv; rd_rs1 = s1; rd_rs2 = s2; resp_ready = rr;
        #1;
        run  = (m_init_left == 0);
        elig = run && rv && !(m_resp_valid && !rr);
        wnz  = run && wv && (wrd != 0);
        wx0  = run && wv && (wrd == 0);
        rg   = elig && (!wnz || m_streak == MAX_WR_STREAK);
        wg   = wnz && !rg;
        check_val("wr_ready", 64'(wr_ready), 64'(wg || wx0));
        check_val("rd_ready", 64'(rd_ready), 64'(rg));
        check_val("rf_read", 64'(rf_read), 64'(!wg));
        check_val("rf_rst", 64'(rf_rst), 64'(!run));
        check_val("init_done", 64'(init_done), 64'(run));
        check_val("rf_idx_data", 64'({rf_rd, rf_rs1, rf_rs2, rf_data_in}),
                  64'({wg ? wrd : 5'd0, rg ? s1 : 5'd0, rg ? s2 : 5'd0, wg ? wd : 32'd0}));
        check_val("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
        if (m_resp_valid) check_val("resp_data", {resp_rs1, resp_rs2}, {m_resp1, m_resp2});
        @(posedge clk);
        if (!run) m_init_left--;
        if (rg) begin
            m_resp_valid = 1'b1;
            m_resp1 = (s1 == 0) ? 32'd0 : m_regs[s1];
            m_resp2 = (s2 == 0) ? 32'd0 : m_regs[s2];
        end else if (m_resp_valid && rr) begin
            m_resp_valid = 1'b0;
        end
        m_streak = (elig && wg) ? m_streak + 1 : 0;
        if (wg) m_regs[wrd] = wd;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, rr);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_rf_rst", 64'(rf_rst), 64'd1);
        check_val("rst_rf_read", 64'(rf_read), 64'd1);
        check_val("rst_init_done", 64'(init_done), 64'd0);
        #1 rst_n = 1'b1;

        // Init window then idle run defaults
        repeat (4) idle(1'b1);

        // Write then read-after-write with an x0 source
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
        idle(1'b1);

        // Bounded write streak against a waiting read
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i + 1), 5'd5, 1'b1);
        idle(1'b1);

        // x0 write alongside a read
        step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd3, 1'b1);
        idle(1'b1);

        // Stalled response survives later writes to the same register
        step(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0);
        repeat (3) step(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b1);
        idle(1'b1);

        // Reset while a response is stalled
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("midrst_rf_rst", 64'(rf_rst), 64'd1);
        check_val("midrst_init_done", 64'(init_done), 64'd0);
        check_val("midrst_rd_ready", 64'(rd_ready), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) idle(1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Single-port scheduler in front of the 32x32 register file, which performs either one read of two sources or one write per clock.
- Arbitrates between the writeback port (write requests) and the decode port (read requests), with a bounded write-priority policy.
- Sequences register-file clear after reset, suppresses x0 writes, and buffers read responses under backpressure.

Parameters:
- MAX_WR_STREAK, 4: maximum consecutive write grants while an eligible read waits; range 1..15.
- INIT_CYCLES, 1: cycles rf_rst is held high after reset release; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_rd  in  5  destination register.
- wr_data  in  32  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_rs1  in  5  source 1 index.
- rd_rs2  in  5  source 2 index.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_rs1  out  32  source 1 value.
- resp_rs2  out  32  source 2 value.
- init_done  out  1  high once in RUN.
- rf_rst  out  1  register-file synchronous clear, active-high.
- rf_read  out  1  1 = read op, 0 = write op.
- rf_rd  out  5  write index.
- rf_rs1  out  5  read index 1.
- rf_rs2  out  5  read index 2.
- rf_data_in  out  32  write data.
- rf_rs1_out  in  32  register-file read data 1. Registered; valid in the cycle after the read op.
- rf_rs2_out  in  32  register-file read data 2. Same timing as rf_rs1_out.

Behaviour:
- Reset asserted (rst=0), asynchronously:
  - state=INIT, init counter=0, streak=0.
  - resp_valid=0, hold register=0, init_done=0.
  - rf_rst=1, rf_read=1.
- FSM INIT:
  - rf_rst=1, both readies 0.
  - Counter counts clocks after rst deasserts; after INIT_CYCLES clocks go to RUN.
- FSM RUN:
  - rf_rst=0, init_done=1.
  - RUN is left only by reset.
- Idle default (any cycle with no granted register-file write, including INIT):
  - rf_read=1, rf_rs1=rf_rs2=rf_rd=0, rf_data_in=0.
  - rf_read is never 0 except on a granted nonzero write.
- Read eligibility: RUN and rd_valid and not (resp_valid and not resp_ready).
  - A read may be granted in the same cycle an existing response is taken.
- x0 writes (wr_rd=0):
  - In RUN, wr_ready=1 immediately and no register-file op is issued.
  - May coincide with any read grant.
  - Does not affect the streak.
- Arbitration for nonzero writes vs an eligible read:
  - Write wins unless streak==MAX_WR_STREAK; then the read wins.
  - Streak increments on a write grant made while an eligible read was refused.
  - Streak clears on a read grant, or in any cycle with no eligible read.
- Exactly one of {nonzero write, read} is granted per cycle.
  - Grants are combinational: ready depends on same-cycle valid.
- Write grant: rf_read=0, rf_rd=wr_rd, rf_data_in=wr_data. Register updated at the cycle-ending edge.
- Read grant: rf_read=1, rf_rs1=rd_rs1, rf_rs2=rd_rs2.
  - resp_valid=1 in the next cycle (latency 1).
  - resp_rs1/resp_rs2 driven from rf_rs1_out/rf_rs2_out in that first cycle.
- Response stalled (resp_valid and not resp_ready):
  - The first-cycle values are captured into the hold register at that edge.
  - resp_* are then driven from the hold register until taken.
  - Later writes, which zero the register-file outputs, must not disturb resp_*.
  - resp_valid drops after a handshake unless a new read was granted in that cycle.
- Ordering:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
  - A read granted before a write returns the old value. No forwarding is needed.
- Source index 0: resp value is forced to 0 regardless of register-file output.
- Reset mid-operation: all pending responses are discarded, the FSM restarts INIT, and the register file is cleared again.

Test Plan:
- INIT_CYCLES=2; release rst -> rf_rst=1 for 2 clocks, wr_ready=rd_ready=0; then init_done=1, rf_rst=0, rf_read=1.
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 the next cycle -> resp_valid one cycle after grant, resp_rs1=0xDEADBEEF, resp_rs2=0.
- MAX_WR_STREAK=2; wr_valid (x1..) and rd_valid held high -> grant sequence W,W,R,W,W,R; exactly one rf op per cycle.
- Write x0=0x1234 concurrent with read rs1=0 -> both readies 1 same cycle, no rf_read=0 cycle, resp_rs1=0.
- x7=0xA, read x7, resp_ready=0 for 3 cycles while writes x7=0xB proceed -> resp_rs1 stays 0xA, rd_ready=0 until taken; next read of x7 -> 0xB.
- Assert rst while a response is stalled -> resp_valid=0 immediately, INIT re-entered, subsequent read of x7 returns 0.
